rhs_spi_master_multi: RTL and testbench

Parametrised SPI master (mode 0, MSB first) for Intan RHS-family headstages. One CS/SCLK/MOSI is broadcast to NUM_MISO chips, and all MISO lanes are captured in parallel.
- Per-transaction programmable MISO sample delay, in clk cycles, compensates cable and isolator round-trip delay.
- SCLK is produced by a registered counter; no clock gating.
- Supports back-to-back transactions; sits between the command sequencer and the headstage pins.

---
 rtl/rhs_spi_master_multi_if.sv | 39 +++
 rtl/rhs_spi_master_multi.sv | 210 +++++++++++++++++++++
 tb/tb_rhs_spi_master_multi.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rhs_spi_master_multi_if.sv
// Bus bundle for rhs_spi_master_multi: sequencer handshake plus headstage SPI pins.
// The loopback input exists only when RHS_SPI_LOOPBACK_EN is defined.
interface rhs_spi_master_multi_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_MISO = 2
);
    logic                         start;
    logic [DATA_W-1:0]            data_in;
    logic [7:0]                   sample_delay;
    logic                         ready;
    logic                         busy;
    logic                         done;
    logic [NUM_MISO*DATA_W-1:0]   data_out;
    logic                         CS;
    logic                         SCLK;
    logic                         MOSI;
    logic [NUM_MISO-1:0]          MISO;
`ifdef RHS_SPI_LOOPBACK_EN
    logic                         loopback;

    modport master (
        input  start, data_in, sample_delay, MISO, loopback,
        output ready, busy, done, data_out, CS, SCLK, MOSI
    );
    modport slave (
        output start, data_in, sample_delay, MISO, loopback,
        input  ready, busy, done, data_out, CS, SCLK, MOSI
    );
`else
    modport master (
        input  start, data_in, sample_delay, MISO,
        output ready, busy, done, data_out, CS, SCLK, MOSI
    );
    modport slave (
        output start, data_in, sample_delay, MISO,
        input  ready, busy, done, data_out, CS, SCLK, MOSI
    );
`endif
endinterface

// File: rtl/rhs_spi_master_multi.sv
// Mode-0 MSB-first SPI master broadcasting to NUM_MISO Intan RHS chips with a per-transaction
// MISO sample delay. Optional feature macro: RHS_SPI_LOOPBACK_EN (samples MOSI instead of MISO).
module rhs_spi_master_multi #(
    parameter int DATA_W    = 32,
    parameter int NUM_MISO  = 2,
    parameter int CLK_DIV   = 8,
    parameter int PRE_PAD   = 8,
    parameter int POST_PAD  = 8,
    parameter int CS_HOLD   = 16,
    parameter int MAX_DELAY = 64
) (
    input  logic                        clk,
    input  logic                        rstn,
    rhs_spi_master_multi_if.master      bus
);
    localparam int DW    = $clog2(MAX_DELAY + 1);
    localparam int DIVW  = $clog2(CLK_DIV);
    localparam int BW    = $clog2(DATA_W);
    localparam int CMAX0 = (PRE_PAD > POST_PAD) ? PRE_PAD : POST_PAD;
    localparam int CMAX1 = (CMAX0 > CS_HOLD) ? CMAX0 : CS_HOLD;
    localparam int CMAX  = (CMAX1 > MAX_DELAY) ? CMAX1 : MAX_DELAY;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int LW    = NUM_MISO * DATA_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_TAIL  = 3'd3;
    localparam logic [2:0] S_POST  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc_s;
    logic [DIVW-1:0]      div_q, div_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_W-1:0]    shreg_q, shreg_d;
    logic [DW-1:0]        delay_q, delay_d, delay_clamp_s;
    logic [MAX_DELAY-1:0] stb_q, stb_d;
    logic [MAX_DELAY:0]   stb_line_s;
    logic                 stb0_s, stb_hit_s, acc_s;
    logic [NUM_MISO-1:0]  src_s;
    logic [LW-1:0]        cap_q, cap_d;
    logic [LW-1:0]        data_out_q, data_out_d;
    logic                 cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic                 busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic                 lb_q, lb_d;

    // Accept happens exactly when ready is shown: in IDLE or in the done cycle.
    assign acc_s         = bus.start & ready_q;
    assign cnt_inc_s     = cnt_q + CW'(1);
    assign delay_clamp_s = (bus.sample_delay > 8'(MAX_DELAY)) ? DW'(MAX_DELAY) : DW'(bus.sample_delay);

`ifdef RHS_SPI_LOOPBACK_EN
    assign lb_d  = acc_s ? bus.loopback : lb_q;
    assign src_s = lb_q ? {NUM_MISO{mosi_q}} : bus.MISO;
`else
    assign lb_d  = 1'b0;
    assign src_s = bus.MISO;
`endif

    // Sequencer: phase counters and transmit shift register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            S_IDLE: begin
                if (acc_s) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                if (cnt_inc_s == CW'(PRE_PAD)) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            S_SHIFT: begin
                if (div_q == DIVW'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (bit_q == BW'(DATA_W - 1)) begin
                        state_d = (delay_q == DW'(0)) ? S_POST : S_TAIL;
                        cnt_d   = '0;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            S_TAIL: begin
                if (cnt_inc_s == CW'(delay_q)) begin
                    state_d = S_POST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            S_POST: begin
                if (cnt_inc_s == CW'(POST_PAD)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            S_HOLD: begin
                if (cnt_inc_s == CW'(CS_HOLD)) begin
                    state_d = acc_s ? S_PRE : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        shreg_d = acc_s ? bus.data_in : shreg_d;
    end

    assign delay_d = acc_s ? delay_clamp_s : delay_q;

    // Strobe line: tap d is the mid-period strobe seen d cycles ago.
    assign stb0_s     = (state_q == S_SHIFT) && (div_q == DIVW'(CLK_DIV / 2));
    assign stb_line_s = {stb_q, stb0_s};
    assign stb_d      = stb_line_s[MAX_DELAY-1:0];
    assign stb_hit_s  = stb_line_s[delay_q];

    // Per-lane capture shift registers.
    always_comb begin
        cap_d = cap_q;
        for (int i = 0; i < NUM_MISO; i++) begin
            if (stb_hit_s) begin
                cap_d[i*DATA_W +: DATA_W] = {cap_q[i*DATA_W +: DATA_W-1], src_s[i]};
            end else begin
                cap_d[i*DATA_W +: DATA_W] = cap_q[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pin and status values are derived from the next state so registers line up with the phase.
    always_comb begin
        done_d     = (state_d == S_HOLD) && (cnt_d == CW'(CS_HOLD - 1));
        ready_d    = (state_d == S_IDLE) || done_d;
        busy_d     = (state_d != S_IDLE);
        cs_d       = (state_d == S_IDLE) || (state_d == S_HOLD);
        sclk_d     = (state_d == S_SHIFT) && (div_d >= DIVW'(CLK_DIV / 2));
        mosi_d     = ((state_d == S_PRE) || (state_d == S_SHIFT)) ? shreg_d[DATA_W-1] : 1'b0;
        data_out_d = done_d ? cap_q : data_out_q;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            delay_q    <= '0;
            stb_q      <= '0;
            cap_q      <= '0;
            data_out_q <= '0;
            lb_q       <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            delay_q    <= delay_d;
            stb_q      <= stb_d;
            cap_q      <= cap_d;
            data_out_q <= data_out_d;
            lb_q       <= lb_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.CS       = cs_q;
    assign bus.SCLK     = sclk_q;
    assign bus.MOSI     = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ready    = ready_q;
    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_rhs_spi_master_multi.sv
// Directed bench for rhs_spi_master_multi: headstage slave model with programmable round-trip delay.
module tb_rhs_spi_master_multi;
    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_fail;

    rhs_spi_master_multi_if #(.DATA_W(32), .NUM_MISO(2)) bus ();

    rhs_spi_master_multi #(
        .DATA_W(32), .NUM_MISO(2), .CLK_DIV(8), .PRE_PAD(8),
        .POST_PAD(8), .CS_HOLD(16), .MAX_DELAY(64)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model: bit k of each word is driven during SCLK period k, delayed by slv_delay clk cycles.
    logic [31:0]  w0 = 32'h0;
    logic [31:0]  w1 = 32'h0;
    int           slv_delay = 0;
    logic [5:0]   bit_idx = 6'd0;
    logic [5:0]   nidx_s;
    logic         sclk_prev = 1'b0;
    logic [127:0] pipe0 = '0;
    logic [127:0] pipe1 = '0;
    logic         raw0_s, raw1_s;

    assign nidx_s = (bus.CS !== 1'b0) ? 6'd0 :
                    ((sclk_prev === 1'b1) && (bus.SCLK === 1'b0)) ? bit_idx + 6'd1 : bit_idx;
    assign raw0_s = (nidx_s < 6'd32) ? w0[5'd31 - nidx_s[4:0]] : 1'b0;
    assign raw1_s = (nidx_s < 6'd32) ? w1[5'd31 - nidx_s[4:0]] : 1'b0;
    assign bus.MISO = {pipe1[slv_delay], pipe0[slv_delay]};

    always @(negedge clk) begin
        bit_idx   <= nidx_s;
        sclk_prev <= (bus.SCLK === 1'b1);
        pipe0     <= {pipe0[126:0], raw0_s};
        pipe1     <= {pipe1[126:0], raw1_s};
    end

    task automatic start_txn(input logic [31:0] din, input logic [7:0] sd, input bit hold);
        bus.start        = 1'b1;
        bus.data_in      = din;
        bus.sample_delay = sd;
        @(posedge clk);
        #1;
        bus.start = hold;
    endtask

    // Called one cycle after accept; watches the pins until done or a cycle budget expires.
    task automatic wait_done(output int cyc, output int rises, output logic [31:0] ms,
                             output int cs_low, output int cs_hi_run, output bit busy_all);
        logic prev;
        prev = 1'b0; rises = 0; ms = 32'h0; cs_low = 0; cs_hi_run = 0; busy_all = 1'b1; cyc = -1;
        for (int c = 1; c <= 2000; c++) begin
            if (bus.busy !== 1'b1) busy_all = 1'b0;
            if (bus.CS === 1'b0) begin
                cs_low++;
                cs_hi_run = 0;
            end else begin
                cs_hi_run++;
            end
            if ((bus.SCLK === 1'b1) && (prev === 1'b0)) begin
                rises++;
                ms = {ms[30:0], bus.MOSI};
            end
            prev = bus.SCLK;
            if (bus.done === 1'b1) begin
                cyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.start = 1'b0; bus.data_in = 32'h0; bus.sample_delay = 8'd0;
`ifdef RHS_SPI_LOOPBACK_EN
        bus.loopback = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.CS !== 1'b1) begin n_fail++; $display("FAIL rst_cs: got %b want 1", bus.CS); end
        n_cmp++; if (bus.SCLK !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b want 0", bus.SCLK); end
        n_cmp++; if (bus.MOSI !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", bus.MOSI); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.ready); end
        n_cmp++; if (bus.data_out !== 64'h0) begin n_fail++; $display("FAIL rst_dout: got %h want 0", bus.data_out); end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int cyc, rises, csl, csh; logic [31:0] ms; bit ball;
        w0 = 32'h12345678; w1 = 32'hDEADBEEF; slv_delay = 0;
        start_txn(32'hA5A50F0F, 8'd0, 1'b0);
        n_cmp++; if (bus.CS !== 1'b0) begin n_fail++; $display("FAIL basic_cs_first: got %b want 0", bus.CS); end
        wait_done(cyc, rises, ms, csl, csh, ball);
        n_cmp++; if (cyc !== 288) begin n_fail++; $display("FAIL basic_done_cyc: got %0d want 288", cyc); end
        n_cmp++; if (rises !== 32) begin n_fail++; $display("FAIL basic_sclk_rises: got %0d want 32", rises); end
        n_cmp++; if (ms !== 32'hA5A50F0F) begin n_fail++; $display("FAIL basic_mosi: got %h want a5a50f0f", ms); end
        n_cmp++; if (bus.data_out[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL basic_lane0: got %h want 12345678", bus.data_out[31:0]); end
        n_cmp++; if (bus.data_out[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_lane1: got %h want deadbeef", bus.data_out[63:32]); end
        n_cmp++; if (ball !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", ball); end
        n_cmp++; if (csl !== 272) begin n_fail++; $display("FAIL basic_cs_low: got %0d want 272", csl); end
        n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_done: got %b want 1", bus.ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", bus.busy); end
        n_cmp++; if (bus.data_out[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL basic_dout_hold: got %h want 12345678", bus.data_out[31:0]); end
    endtask

    task automatic test_delay();
        int cyc, rises, csl, csh; logic [31:0] ms; bit ball;
        w0 = 32'h12345678; w1 = 32'hDEADBEEF; slv_delay = 5;
        repeat (2) @(posedge clk);
        #1;
        start_txn(32'h3C3C3C3C, 8'd5, 1'b0);
        bus.data_in = 32'hFFFFFFFF; bus.sample_delay = 8'd0;
        wait_done(cyc, rises, ms, csl, csh, ball);
        n_cmp++; if (cyc !== 293) begin n_fail++; $display("FAIL dly5_done_cyc: got %0d want 293", cyc); end
        n_cmp++; if (ms !== 32'h3C3C3C3C) begin n_fail++; $display("FAIL dly5_mosi: got %h want 3c3c3c3c", ms); end
        n_cmp++; if (bus.data_out[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL dly5_lane0: got %h want 12345678", bus.data_out[31:0]); end
        n_cmp++; if (bus.data_out[63:32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dly5_lane1: got %h want deadbeef", bus.data_out[63:32]); end
        @(posedge clk);
        #1;
        start_txn(32'h3C3C3C3C, 8'd0, 1'b0);
        wait_done(cyc, rises, ms, csl, csh, ball);
        n_cmp++; if (cyc !== 288) begin n_fail++; $display("FAIL dly0_done_cyc: got %0d want 288", cyc); end
        n_cmp++; if (bus.data_out[31:0] !== 32'h091A2B3C) begin n_fail++; $display("FAIL dly0_missample0: got %h want 091a2b3c", bus.data_out[31:0]); end
        n_cmp++; if (bus.data_out[63:32] === 32'hDEADBEEF) begin n_fail++; $display("FAIL dly0_missample1: got %h want not deadbeef", bus.data_out[63:32]); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clamp();
        int cyc, rises, csl, csh; logic [31:0] ms; bit ball;
        w0 = 32'hCAFEF00D; w1 = 32'h0BADC0DE; slv_delay = 64;
        start_txn(32'h80000001, 8'd200, 1'b0);
        wait_done(cyc, rises, ms, csl, csh, ball);
        n_cmp++; if (cyc !== 352) begin n_fail++; $display("FAIL clamp_done_cyc: got %0d want 352", cyc); end
        n_cmp++; if (csl !== 336) begin n_fail++; $display("FAIL clamp_cs_low: got %0d want 336", csl); end
        n_cmp++; if (bus.data_out[31:0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL clamp_lane0: got %h want cafef00d", bus.data_out[31:0]); end
        n_cmp++; if (bus.data_out[63:32] !== 32'h0BADC0DE) begin n_fail++; $display("FAIL clamp_lane1: got %h want 0badc0de", bus.data_out[63:32]); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int cyc, rises, csl, csh; logic [31:0] ms; bit ball;
        w0 = 32'h11112222; w1 = 32'h33334444; slv_delay = 0;
        start_txn(32'h0000FFFF, 8'd0, 1'b1);
        wait_done(cyc, rises, ms, csl, csh, ball);
        n_cmp++; if (cyc !== 288) begin n_fail++; $display("FAIL b2b_done1: got %0d want 288", cyc); end
        n_cmp++; if (csh !== 16) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d want 16", csh); end
        n_cmp++; if (ms !== 32'h0000FFFF) begin n_fail++; $display("FAIL b2b_mosi1: got %h want 0000ffff", ms); end
        bus.data_in = 32'h96696996;
        w0 = 32'h55556666; w1 = 32'h77778888;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.CS !== 1'b0) begin n_fail++; $display("FAIL b2b_cs_fall: got %b want 0", bus.CS); end
        bus.data_in = 32'hFFFF0000;
        wait_done(cyc, rises, ms, csl, csh, ball);
        bus.start = 1'b0;
        n_cmp++; if (cyc !== 288) begin n_fail++; $display("FAIL b2b_done2: got %0d want 288", cyc); end
        n_cmp++; if (ms !== 32'h96696996) begin n_fail++; $display("FAIL b2b_mosi2: got %h want 96696996", ms); end
        n_cmp++; if (bus.data_out !== {32'h77778888, 32'h55556666}) begin n_fail++; $display("FAIL b2b_dout2: got %h want 7777888855556666", bus.data_out); end
        n_cmp++; if (ball !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", ball); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({bus.CS, bus.busy, bus.ready} !== 3'b101) begin n_fail++; $display("FAIL b2b_idle: got %b want 101", {bus.CS, bus.busy, bus.ready}); end
    endtask

    task automatic test_reset_mid();
        int cyc, rises, csl, csh, ndone; logic [31:0] ms; bit ball;
        w0 = 32'h12345678; w1 = 32'hDEADBEEF; slv_delay = 0;
        start_txn(32'hA5A50F0F, 8'd0, 1'b0);
        repeat (90) @(posedge clk);
        #1;
        n_cmp++; if (bus.CS !== 1'b0) begin n_fail++; $display("FAIL rmid_in_shift: got %b want 0", bus.CS); end
        rstn = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if ({bus.CS, bus.SCLK, bus.MOSI, bus.busy, bus.done} !== 5'b10000) begin n_fail++; $display("FAIL rmid_pins: got %b want 10000", {bus.CS, bus.SCLK, bus.MOSI, bus.busy, bus.done}); end
        n_cmp++; if (bus.data_out !== 64'h0) begin n_fail++; $display("FAIL rmid_dout: got %h want 0", bus.data_out); end
        rstn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 350; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        n_cmp++; if (ndone !== 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d want 0", ndone); end
        start_txn(32'hA5A50F0F, 8'd0, 1'b0);
        wait_done(cyc, rises, ms, csl, csh, ball);
        n_cmp++; if (cyc !== 288) begin n_fail++; $display("FAIL rmid_done_cyc: got %0d want 288", cyc); end
        n_cmp++; if (bus.data_out !== {32'hDEADBEEF, 32'h12345678}) begin n_fail++; $display("FAIL rmid_dout_after: got %h want deadbeef12345678", bus.data_out); end
        @(posedge clk);
        #1;
    endtask

`ifdef RHS_SPI_LOOPBACK_EN
    task automatic test_loopback();
        int cyc, rises, csl, csh; logic [31:0] ms; bit ball;
        w0 = 32'h0; w1 = 32'hFFFFFFFF; slv_delay = 0;
        bus.loopback = 1'b1;
        start_txn(32'h0F1E2D3C, 8'd0, 1'b0);
        bus.loopback = 1'b0;
        wait_done(cyc, rises, ms, csl, csh, ball);
        n_cmp++; if (bus.data_out !== {32'h0F1E2D3C, 32'h0F1E2D3C}) begin n_fail++; $display("FAIL loopback_dout: got %h want 0f1e2d3c0f1e2d3c", bus.data_out); end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_delay();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
`ifdef RHS_SPI_LOOPBACK_EN
        test_loopback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
